// File: rtl/candidate_checker_pkg.sv
// Shared types and constants for the candidate checker: FSM state encoding,
// the lowercase ASCII range of candidate letters and the default word length.
package candidate_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        FOUND,
        EXHAUSTED
    } state_t;

    localparam logic [7:0] ASCII_A = 8'h61;
    localparam logic [7:0] ASCII_Z = 8'h7A;

    localparam int NUM_LETTERS_DEFAULT = 4;

endpackage

// File: rtl/candidate_checker_target_loader.sv
// Target word register: letters arrive one per cycle, first letter lands in
// the most significant byte; full goes high once every position is written.
module target_loader
    import candidate_checker_pkg::*;
#(
    parameter int NUM_LETTERS = NUM_LETTERS_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     begin_load,
    input  logic                     load_next,
    input  logic [7:0]               target_char,
    output logic [8*NUM_LETTERS-1:0] target,
    output logic                     full
);

    localparam int WORD_W = 8 * NUM_LETTERS;
    localparam int CNT_W  = $clog2(NUM_LETTERS + 1);

    logic [CNT_W-1:0] load_count;

    assign full = (load_count == CNT_W'(NUM_LETTERS));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches the netlist.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            target     <= '0;
            load_count <= '0;
        end else if (begin_load) begin
            // A fresh load wipes stale letters from any earlier target.
            target                    <= '0;
            target[WORD_W-1 -: 8]     <= target_char;
            load_count                <= CNT_W'(1);
        end else if (load_next && !full) begin
            for (int i = 1; i < NUM_LETTERS; i++) begin
                if (load_count == CNT_W'(i)) begin
                    target[8*(NUM_LETTERS-1-i) +: 8] <= target_char;
                end
            end
            load_count <= load_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/candidate_checker.sv
// Compares a stream of candidate words from a counter chain against a loaded
// target through a two-stage pipeline and reports the first match or exhaustion.
module candidate_checker
    import candidate_checker_pkg::*;
#(
    parameter int NUM_LETTERS = NUM_LETTERS_DEFAULT,
    parameter int ATTEMPT_W   = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     target_load,
    input  logic [7:0]               target_char,
    input  logic                     start,
    input  logic [8*NUM_LETTERS-1:0] candidate,
    input  logic                     candidate_valid,
    input  logic                     last_candidate,
    output logic                     ready,
    output logic                     found,
    output logic                     done,
    output logic [8*NUM_LETTERS-1:0] match_word,
    output logic [ATTEMPT_W-1:0]     attempts
);

    localparam int WORD_W = 8 * NUM_LETTERS;

    state_t            state;
    logic              s1_valid;
    logic              s1_last;
    logic [WORD_W-1:0] s1_word;
    logic [WORD_W-1:0] target;
    logic              target_full;
    logic              idle_or_ended;
    logic              begin_load;
    logic              load_next;
    logic              go_search;
    logic              accept;
    logic              is_match;

    assign idle_or_ended = (state == IDLE) || (state == FOUND) || (state == EXHAUSTED);
    assign begin_load    = target_load && idle_or_ended;
    assign load_next     = target_load && (state == LOAD);
    // A load request wins over start when both arrive together.
    assign go_search     = start && !target_load && target_full && idle_or_ended;
    assign accept        = candidate_valid && ready;
    assign is_match      = (s1_word == target);

    target_loader #(
        .NUM_LETTERS(NUM_LETTERS)
    ) u_target_loader (
        .clock      (clock),
        .reset      (reset),
        .begin_load (begin_load),
        .load_next  (load_next),
        .target_char(target_char),
        .target     (target),
        .full       (target_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            found      <= 1'b0;
            done       <= 1'b0;
            match_word <= '0;
            attempts   <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_word    <= '0;
        end else if (go_search) begin
            state    <= SEARCH;
            ready    <= 1'b1;
            found    <= 1'b0;
            done     <= 1'b0;
            attempts <= '0;
            s1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (target_load) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!target_load) begin
                        state <= IDLE;
                    end
                end
                SEARCH: begin
                    s1_valid <= accept;
                    if (accept) begin
                        s1_word <= candidate;
                        s1_last <= last_candidate;
                    end
                    if (s1_valid) begin
                        if (attempts != '1) begin
                            attempts <= attempts + ATTEMPT_W'(1);
                        end
                        // Ending the search drops whatever was accepted behind this word.
                        if (is_match) begin
                            state      <= FOUND;
                            found      <= 1'b1;
                            done       <= 1'b1;
                            ready      <= 1'b0;
                            match_word <= s1_word;
                            s1_valid   <= 1'b0;
                        end else if (s1_last) begin
                            state    <= EXHAUSTED;
                            done     <= 1'b1;
                            ready    <= 1'b0;
                            s1_valid <= 1'b0;
                        end
                    end
                end
                FOUND, EXHAUSTED: begin
                    if (target_load) begin
                        state <= LOAD;
                        found <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_candidate_checker.sv
// Randomized scoreboard bench for candidate_checker: a stream-level reference
// model predicts each search outcome, a negedge monitor checks it when done rises.
module tb_candidate_checker;
    import candidate_checker_pkg::*;

    localparam int NL = 4;
    localparam int AW = 24;
    localparam int WW = 8 * NL;

    localparam logic [WW-1:0] WORD_ABCD = 32'h61626364;
    localparam logic [WW-1:0] WORD_ZZZZ = 32'h7A7A7A7A;
    localparam logic [WW-1:0] WORD_AAAA = 32'h61616161;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          target_load = 1'b0;
    logic [7:0]    target_char = '0;
    logic          start = 1'b0;
    logic [WW-1:0] candidate = '0;
    logic          candidate_valid = 1'b0;
    logic          last_candidate = 1'b0;
    logic          ready;
    logic          found;
    logic          done;
    logic [WW-1:0] match_word;
    logic [AW-1:0] attempts;

    candidate_checker #(
        .NUM_LETTERS(NL),
        .ATTEMPT_W  (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .target_load    (target_load),
        .target_char    (target_char),
        .start          (start),
        .candidate      (candidate),
        .candidate_valid(candidate_valid),
        .last_candidate (last_candidate),
        .ready          (ready),
        .found          (found),
        .done           (done),
        .match_word     (match_word),
        .attempts       (attempts)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic          found;
        logic [WW-1:0] word;
        int            attempts;
        int            term_idx;
    } exp_t;

    int            checks = 0;
    int            failures = 0;
    exp_t          exp_q[$];
    exp_t          last_exp;
    exp_t          mon_e;
    logic [WW-1:0] stim_words[$];
    logic          stim_lasts[$];
    int            acc_cyc[$];
    logic          done_q = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] rand_letter();
        return 8'(int'(ASCII_A) + int'($urandom_range(int'(ASCII_Z - ASCII_A))));
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int p = 0; p < NL; p++) w[8*p +: 8] = rand_letter();
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_other(input logic [WW-1:0] tgt);
        logic [WW-1:0] w;
        w = rand_word();
        while (w == tgt) w = rand_word();
        return w;
    endfunction

    // Word number n in the counter chain's order: base-26 digits, last letter fastest.
    function automatic logic [WW-1:0] word_from_index(input int n);
        logic [WW-1:0] w;
        int            r;
        r = n;
        for (int p = 0; p < NL; p++) begin
            w[8*p +: 8] = 8'(int'(ASCII_A) + r % 26);
            r = r / 26;
        end
        return w;
    endfunction

    // Outcome of a search over the queued stream: the first word equal to the
    // target or carrying the last flag ends it, and only words up to it count.
    function automatic exp_t model(input logic [WW-1:0] tgt);
        exp_t r;
        r.found    = 1'b0;
        r.word     = '0;
        r.attempts = 0;
        r.term_idx = -1;
        for (int i = 0; i < stim_words.size(); i++) begin
            r.attempts = i + 1;
            r.term_idx = i;
            if (stim_words[i] == tgt) begin
                r.found = 1'b1;
                r.word  = tgt;
                return r;
            end
            if (stim_lasts[i]) return r;
        end
        r.term_idx = -1;
        return r;
    endfunction

    always @(negedge clock) begin : monitor
        if (!reset && done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_found", 64'(found), 64'(mon_e.found));
                if (mon_e.found) check("sb_match_word", 64'(match_word), 64'(mon_e.word));
                check("sb_attempts", 64'(attempts), 64'(mon_e.attempts));
                check("sb_ready_low", 64'(ready), 64'd0);
                if (mon_e.term_idx >= 0 && mon_e.term_idx < acc_cyc.size())
                    check("sb_latency", 64'(cyc - acc_cyc[mon_e.term_idx]), 64'd2);
                else
                    check("sb_term_accepted", 64'd0, 64'd1);
            end
        end
        done_q <= done;
    end

    task automatic load_word(input logic [WW-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            target_load = 1'b1;
            target_char = w[8*(NL-1-i) +: 8];
        end
        @(negedge clock);
        target_load = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic build_random(input logic [WW-1:0] tgt, input int len, input bit put_match);
        int mpos;
        mpos = put_match ? int'($urandom_range(len - 1)) : -1;
        stim_words.delete();
        stim_lasts.delete();
        for (int i = 0; i < len; i++) begin
            stim_words.push_back((i == mpos) ? tgt : rand_other(tgt));
            stim_lasts.push_back(i == len - 1);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
        @(negedge clock);
    endtask

    // Predict, then start the search and feed the stream, advancing only on acceptance.
    task automatic run_search(input logic [WW-1:0] tgt, input int bubble_pct);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        last_exp = model(tgt);
        exp_q.push_back(last_exp);
        acc_cyc.delete();
        pulse_start();
        while (guard < 4000) begin
            candidate_valid = 1'b0;
            last_candidate  = 1'b0;
            if (done || idx >= stim_words.size()) break;
            if (ready && int'($urandom_range(99)) >= bubble_pct) begin
                candidate_valid = 1'b1;
                candidate       = stim_words[idx];
                last_candidate  = stim_lasts[idx];
                acc_cyc.push_back(cyc);
                idx++;
            end
            @(negedge clock);
            guard++;
        end
        candidate_valid = 1'b0;
        last_candidate  = 1'b0;
        wait_done();
    endtask

    initial begin : stimulus
        logic [WW-1:0] tgt;

        repeat (2) @(negedge clock);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_found", 64'(found), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_match_word", 64'(match_word), 64'd0);
        check("reset_attempts", 64'(attempts), 64'd0);
        reset = 1'b0;

        // Three letters only: start must be ignored.
        load_word(WORD_ABCD, 3);
        pulse_start();
        repeat (3) @(negedge clock);
        check("short_load_ready", 64'(ready), 64'd0);
        check("short_load_done", 64'(done), 64'd0);

        // Full ordered sweep up to "abcd" plus two trailing words.
        load_word(WORD_ABCD, 4);
        stim_words.delete();
        stim_lasts.delete();
        for (int i = 0; i < 734; i++) begin
            stim_words.push_back(word_from_index(i));
            stim_lasts.push_back(1'b0);
        end
        run_search(WORD_ABCD, 0);
        repeat (4) @(negedge clock);
        check("sweep_found_hold", 64'(found), 64'd1);
        check("sweep_done_hold", 64'(done), 64'd1);
        check("sweep_match_word", 64'(match_word), 64'(WORD_ABCD));
        check("sweep_attempts", 64'(attempts), 64'd732);
        check("sweep_ready_hold", 64'(ready), 64'd0);

        // Restart from FOUND with the same target: ten misses, last on the tenth.
        build_random(WORD_ABCD, 10, 1'b0);
        run_search(WORD_ABCD, 20);
        check("exhaust_found", 64'(found), 64'd0);
        check("exhaust_done", 64'(done), 64'd1);
        check("exhaust_attempts", 64'(attempts), 64'd10);

        // Match and last flag on the same word: match wins.
        load_word(WORD_ZZZZ, 4);
        build_random(WORD_ZZZZ, 6, 1'b0);
        stim_words[5] = WORD_ZZZZ;
        run_search(WORD_ZZZZ, 0);
        check("zzzz_found", 64'(found), 64'd1);
        check("zzzz_done", 64'(done), 64'd1);

        for (int t = 0; t < 8; t++) begin
            tgt = rand_word();
            load_word(tgt, 4);
            build_random(tgt, 3 + int'($urandom_range(27)), bit'($urandom_range(1)));
            run_search(tgt, 30);
        end

        // Reset in the middle of a search.
        load_word(WORD_ABCD, 4);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            candidate_valid = 1'b1;
            candidate       = WORD_AAAA;
            last_candidate  = 1'b0;
            @(negedge clock);
        end
        check("pre_reset_attempts_nonzero", 64'(attempts != '0), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_ready", 64'(ready), 64'd0);
        check("midreset_found", 64'(found), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_attempts", 64'(attempts), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        candidate_valid = 1'b0;
        pulse_start();
        repeat (3) @(negedge clock);
        check("post_reset_start_ignored", 64'(ready), 64'd0);

        load_word(WORD_ABCD, 4);
        build_random(WORD_ABCD, 6, 1'b1);
        run_search(WORD_ABCD, 0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
